// File: rtl/fixed_point_issue_seq.sv
// Issue sequencer for the rv32v fixed-point datapath: accepts one decoded
// instruction, issues active elements one by one and tracks responses and vxsat.
module fixed_point_issue_seq #(
  parameter int LEN_CSR = 64,
  parameter int MAX_VL  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_op,
  input  logic [2:0]                 in_vsew,
  input  logic [1:0]                 in_vxrm,
  input  logic                       in_vm,
  input  logic [4:0]                 in_vs1,
  input  logic [4:0]                 in_vs2,
  input  logic [4:0]                 in_vd,
  input  logic [LEN_CSR-1:0]         in_vl,
  input  logic [MAX_VL-1:0]          in_v0_mask,
  output logic                       dp_valid,
  input  logic                       dp_ready,
  output logic [5:0]                 dp_op,
  output logic [2:0]                 dp_vsew,
  output logic [1:0]                 dp_vxrm,
  output logic [4:0]                 dp_vs1,
  output logic [4:0]                 dp_vs2,
  output logic [4:0]                 dp_vd,
  output logic [$clog2(MAX_VL)-1:0]  dp_elem_idx,
  input  logic                       dp_resp_valid,
  input  logic                       dp_resp_sat,
  input  logic                       vxsat_clr,
  output logic                       vxsat,
  output logic                       busy,
  output logic                       done,
  output logic                       illegal
);
  localparam int IW = $clog2(MAX_VL);
  localparam int VW = $clog2(MAX_VL + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [2:0]          vsew_q, vsew_d;
  logic [1:0]          vxrm_q, vxrm_d;
  logic [4:0]          vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic                vm_q, vm_d;
  logic [MAX_VL-1:0]   mask_q, mask_d;
  logic [VW-1:0]       evl_q, evl_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [OW-1:0]       out_q, out_d;
  logic                vxsat_q, vxsat_d;
  logic                illegal_q, illegal_d;

  logic          legal, accept, elem_active, xfer, resp_eff, advance, last_elem;
  logic [VW-1:0] evl_in;

  assign legal       = (in_op != 6'd0) && (in_op <= 6'd32) && (in_vsew <= 3'd2);
  assign accept      = (state_q == S_IDLE) && in_valid;
  assign evl_in      = (in_vl > LEN_CSR'(MAX_VL)) ? VW'(MAX_VL) : in_vl[VW-1:0];
  assign elem_active = vm_q | mask_q[idx_q];
  assign xfer        = dp_valid && dp_ready;
  // Responses with nothing outstanding are dropped so the counter never wraps.
  assign resp_eff    = dp_resp_valid && (out_q != '0);
  assign advance     = (state_q == S_ISSUE) && (xfer || !elem_active);
  assign last_elem   = (VW'(idx_q) == evl_q - VW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && legal) state_d = (evl_in == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (advance && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (out_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Throttle on the registered count: a same-cycle response does not free a slot.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    dp_valid = (state_q == S_ISSUE) && elem_active && (out_q < OW'(MAX_OUT));
  end

  always_comb begin
    op_d      = op_q;
    vsew_d    = vsew_q;
    vxrm_d    = vxrm_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vd_d      = vd_q;
    vm_d      = vm_q;
    mask_d    = mask_q;
    evl_d     = evl_q;
    idx_d     = idx_q;
    illegal_d = 1'b0;
    if (accept) begin
      if (!legal) begin
        illegal_d = 1'b1;
      end else begin
        op_d   = in_op;
        vsew_d = in_vsew;
        vxrm_d = in_vxrm;
        vs1_d  = in_vs1;
        vs2_d  = in_vs2;
        vd_d   = in_vd;
        vm_d   = in_vm;
        mask_d = in_v0_mask;
        evl_d  = evl_in;
        idx_d  = '0;
      end
    end
    if (advance) idx_d = idx_q + IW'(1);
    out_d = out_q + OW'(xfer) - OW'(resp_eff);
    // Set has priority over a simultaneous CSR clear.
    if (dp_resp_valid && dp_resp_sat) vxsat_d = 1'b1;
    else if (vxsat_clr)               vxsat_d = 1'b0;
    else                              vxsat_d = vxsat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      vsew_q    <= '0;
      vxrm_q    <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      vm_q      <= 1'b0;
      mask_q    <= '0;
      evl_q     <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      vxsat_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      vsew_q    <= vsew_d;
      vxrm_q    <= vxrm_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vd_q      <= vd_d;
      vm_q      <= vm_d;
      mask_q    <= mask_d;
      evl_q     <= evl_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      vxsat_q   <= vxsat_d;
      illegal_q <= illegal_d;
    end
  end

  assign dp_op       = op_q;
  assign dp_vsew     = vsew_q;
  assign dp_vxrm     = vxrm_q;
  assign dp_vs1      = vs1_q;
  assign dp_vs2      = vs2_q;
  assign dp_vd       = vd_q;
  assign dp_elem_idx = idx_q;
  assign vxsat       = vxsat_q;
  assign illegal     = illegal_q;

endmodule
